// File: rtl/branch_predictor_unit.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating
// counters, looked up combinationally by fetchPC, trained by EX resolution,
// plus mispredict detection that issues a registered redirect and flush.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   fetchPC                    current fetch PC (lookup key)
//   predTaken, predTarget      next-PC mux select and branch-target input
//   resValid/resPC/resTaken/resTarget/resPredTaken/resPredTarget
//                              branch resolution from EX with its prediction
//   redirectValid, redirectPC  one-cycle redirect pulse and corrected next PC
//   flush                      squash younger stages for FLUSH_CYCLES cycles
//   statBranches, statMispredicts  8-bit saturating counters
//
// Optional feature: define BP_STATS_EN to enable the statistics counters;
// otherwise both stat outputs are tied to zero.
module branch_predictor_unit #(
    parameter int unsigned PC_W         = 4,
    parameter int unsigned ENTRIES      = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] fetchPC,
    output logic            predTaken,
    output logic [PC_W-1:0] predTarget,
    input  logic            resValid,
    input  logic [PC_W-1:0] resPC,
    input  logic            resTaken,
    input  logic [PC_W-1:0] resTarget,
    input  logic            resPredTaken,
    input  logic [PC_W-1:0] resPredTarget,
    output logic            redirectValid,
    output logic [PC_W-1:0] redirectPC,
    output logic            flush,
    output logic [7:0]      statBranches,
    output logic [7:0]      statMispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [0:0] {S_IDLE, S_FLUSH} state_t;

    // BTB storage
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    state_t             state_q;
    logic [FC_W-1:0]    fcnt_q;

    // Fetch-side lookup (sees pre-update contents on a same-cycle write)
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = fetchPC[IDX_W+1:2];
    assign f_tag = fetchPC[PC_W-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign predTaken  = f_hit && ctr_q[f_idx][1];
    assign predTarget = f_hit ? tgt_q[f_idx] : fetchPC + PC_W'(4);

    // Resolution side: acceptance and mispredict detection
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             accept;
    logic [PC_W-1:0]  r_seq;
    logic [PC_W-1:0]  act_next;
    logic [PC_W-1:0]  pred_next;
    logic             mispredict;

    assign r_idx      = resPC[IDX_W+1:2];
    assign r_tag      = resPC[PC_W-1:IDX_W+2];
    assign r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign accept     = resValid && (state_q == S_IDLE);
    assign r_seq      = resPC + PC_W'(4);
    assign act_next   = resTaken ? resTarget : r_seq;
    assign pred_next  = resPredTaken ? resPredTarget : r_seq;
    assign mispredict = accept && (act_next != pred_next);

    // BTB training on accepted resolutions; wrong-path ops in FLUSH are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (accept) begin
            if (r_hit) begin
                if (resTaken) begin
                    if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
                    tgt_q[r_idx] <= resTarget;
                end else if (ctr_q[r_idx] != 2'b00) begin
                    ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
                end
            end else if (resTaken) begin
                valid_q[r_idx] <= 1'b1;
                tag_q[r_idx]   <= r_tag;
                tgt_q[r_idx]   <= resTarget;
                ctr_q[r_idx]   <= 2'b10;
            end
        end
    end

    // Redirect/flush FSM: flush is high exactly while in S_FLUSH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fcnt_q        <= '0;
            redirectValid <= 1'b0;
            redirectPC    <= '0;
            flush         <= 1'b0;
        end else begin
            redirectValid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mispredict) begin
                        state_q       <= S_FLUSH;
                        redirectValid <= 1'b1;
                        redirectPC    <= act_next;
                        flush         <= 1'b1;
                        fcnt_q        <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                S_FLUSH: begin
                    if (fcnt_q == '0) begin
                        state_q <= S_IDLE;
                        flush   <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - FC_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BP_STATS_EN
    // Saturating statistics, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statBranches    <= 8'd0;
            statMispredicts <= 8'd0;
        end else begin
            if (accept && (statBranches != 8'hff))
                statBranches <= statBranches + 8'd1;
            if (mispredict && (statMispredicts != 8'hff))
                statMispredicts <= statMispredicts + 8'd1;
        end
    end
`else
    assign statBranches    = 8'd0;
    assign statMispredicts = 8'd0;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fetchPC;
    logic       predTaken;
    logic [3:0] predTarget;
    logic       resValid;
    logic [3:0] resPC;
    logic       resTaken;
    logic [3:0] resTarget;
    logic       resPredTaken;
    logic [3:0] resPredTarget;
    logic       redirectValid;
    logic [3:0] redirectPC;
    logic       flush;
    logic [7:0] statBranches;
    logic [7:0] statMispredicts;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef BP_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    branch_predictor_unit #(.PC_W(4), .ENTRIES(2), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetchPC        (fetchPC),
        .predTaken      (predTaken),
        .predTarget     (predTarget),
        .resValid       (resValid),
        .resPC          (resPC),
        .resTaken       (resTaken),
        .resTarget      (resTarget),
        .resPredTaken   (resPredTaken),
        .resPredTarget  (resPredTarget),
        .redirectValid  (redirectValid),
        .redirectPC     (redirectPC),
        .flush          (flush),
        .statBranches   (statBranches),
        .statMispredicts(statMispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fpc;
        logic       rv;
        logic [3:0] rpc;
        logic       rtk;
        logic [3:0] rtgt;
        logic       rpt;
        logic [3:0] rptgt;
        logic       ept;    // expected predTaken before the edge
        logic [3:0] eptgt;  // expected predTarget before the edge
        logic       erv;    // expected redirectValid after the edge
        logic [3:0] erpc;   // expected redirectPC after the edge
        logic       efl;    // expected flush after the edge
        int         sb;     // expected statBranches after the edge (stats enabled)
        int         sm;     // expected statMispredicts after the edge (stats enabled)
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] fpc, input logic rv, input logic [3:0] rpc,
                                input logic rtk, input logic [3:0] rtgt, input logic rpt,
                                input logic [3:0] rptgt, input logic ept, input logic [3:0] eptgt,
                                input logic erv, input logic [3:0] erpc, input logic efl,
                                input int sb, input int sm);
        vec_t v;
        v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rtk = rtk; v.rtgt = rtgt;
        v.rpt = rpt; v.rptgt = rptgt; v.ept = ept; v.eptgt = eptgt;
        v.erv = erv; v.erpc = erpc; v.efl = efl; v.sb = sb; v.sm = sm;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fetchPC       = v.fpc;
        resValid      = v.rv;
        resPC         = v.rpc;
        resTaken      = v.rtk;
        resTarget     = v.rtgt;
        resPredTaken  = v.rpt;
        resPredTarget = v.rptgt;
    endtask

    initial begin
        //              fpc rv rpc tk tgt pt ptg | ept eptg | erv erpc efl | sb sm
        // reset state
        vecs[0]  = mk(4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd4,  0, 4'd0,  0, 0, 0);
        // first taken at PC=4 mispredicts: redirect to 12, flush 2 cycles
        vecs[1]  = mk(4'd4,  1, 4'd4,  1, 4'd12, 0, 4'd0,  0, 4'd8,  1, 4'd12, 1, 1, 1);
        vecs[2]  = mk(4'd4,  0, 4'd0,  0, 4'd0,  0, 4'd0,  1, 4'd12, 0, 4'd12, 1, 1, 1);
        vecs[3]  = mk(4'd4,  0, 4'd0,  0, 4'd0,  0, 4'd0,  1, 4'd12, 0, 4'd12, 0, 1, 1);
        // three correctly predicted taken: ctr 10 -> 11 -> 11 -> 11
        vecs[4]  = mk(4'd4,  1, 4'd4,  1, 4'd12, 1, 4'd12, 1, 4'd12, 0, 4'd12, 0, 2, 1);
        vecs[5]  = mk(4'd4,  1, 4'd4,  1, 4'd12, 1, 4'd12, 1, 4'd12, 0, 4'd12, 0, 3, 1);
        vecs[6]  = mk(4'd4,  1, 4'd4,  1, 4'd12, 1, 4'd12, 1, 4'd12, 0, 4'd12, 0, 4, 1);
        // not-taken (predicted not-taken, no mispredict): ctr 11 -> 10
        vecs[7]  = mk(4'd4,  1, 4'd4,  0, 4'd0,  0, 4'd0,  1, 4'd12, 0, 4'd12, 0, 5, 1);
        vecs[8]  = mk(4'd4,  0, 4'd0,  0, 4'd0,  0, 4'd0,  1, 4'd12, 0, 4'd12, 0, 5, 1);
        // second not-taken: ctr 10 -> 01
        vecs[9]  = mk(4'd4,  1, 4'd4,  0, 4'd0,  0, 4'd0,  1, 4'd12, 0, 4'd12, 0, 6, 1);
        vecs[10] = mk(4'd4,  0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd12, 0, 4'd12, 0, 6, 1);
        // alias PC=12: miss, fall-through wraps to 0
        vecs[11] = mk(4'd12, 0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd12, 0, 6, 1);
        vecs[12] = mk(4'd12, 1, 4'd12, 1, 4'd8,  0, 4'd0,  0, 4'd0,  1, 4'd8,  1, 7, 2);
        vecs[13] = mk(4'd12, 0, 4'd0,  0, 4'd0,  0, 4'd0,  1, 4'd8,  0, 4'd8,  1, 7, 2);
        vecs[14] = mk(4'd4,  0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd8,  0, 4'd8,  0, 7, 2);
        // wrap-around mispredict: not taken at 12 -> redirect to 0; ctr 10 -> 01
        vecs[15] = mk(4'd0,  1, 4'd12, 0, 4'd0,  1, 4'd4,  0, 4'd4,  1, 4'd0,  1, 8, 3);
        // squashed resolution during flush: no update, no redirect, no stats
        vecs[16] = mk(4'd12, 1, 4'd12, 1, 4'd4,  0, 4'd0,  0, 4'd8,  0, 4'd0,  1, 8, 3);
        vecs[17] = mk(4'd12, 0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 4'd8,  0, 4'd0,  0, 8, 3);

        reset = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d predTaken", i),  int'(predTaken),  int'(vecs[i].ept));
            chk($sformatf("v%0d predTarget", i), int'(predTarget), int'(vecs[i].eptgt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d redirectValid", i), int'(redirectValid), int'(vecs[i].erv));
            chk($sformatf("v%0d redirectPC", i),    int'(redirectPC),    int'(vecs[i].erpc));
            chk($sformatf("v%0d flush", i),         int'(flush),         int'(vecs[i].efl));
            chk($sformatf("v%0d statBranches", i),    int'(statBranches),    STATS_ON ? vecs[i].sb : 0);
            chk($sformatf("v%0d statMispredicts", i), int'(statMispredicts), STATS_ON ? vecs[i].sm : 0);
        end

        // Reset mid-flush: mispredict at PC=0 (taken to 8), then async reset
        drive(mk(4'd12, 1, 4'd0, 1, 4'd8, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("midflush pre flush", int'(flush), 1);
        chk("midflush pre redirectValid", int'(redirectValid), 1);
        chk("midflush pre redirectPC", int'(redirectPC), 8);
        resValid = 1'b0;
        fetchPC  = 4'd12;
        reset    = 1'b1;
        #1;
        chk("midflush flush", int'(flush), 0);
        chk("midflush redirectValid", int'(redirectValid), 0);
        chk("midflush redirectPC", int'(redirectPC), 0);
        chk("midflush statBranches", int'(statBranches), 0);
        chk("midflush statMispredicts", int'(statMispredicts), 0);
        chk("midflush predTaken", int'(predTaken), 0);
        chk("midflush predTarget", int'(predTarget), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postreset flush", int'(flush), 0);
        chk("postreset redirectValid", int'(redirectValid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Producer side of the fetch-stage next-PC 2:1 select: drives the select line (predicted taken) and the branch-target input of the existing 4-bit next-PC mux each cycle.
- Holds a small direct-mapped branch target buffer with 2-bit saturating counters, looked up combinationally by the fetch PC.
- Trained by branch resolution from EX.
- Detects mispredicts and issues a registered redirect plus a timed pipeline flush.

Parameters:
- PC_W, 4, PC width; PC increment fixed at 4, PC[1:0] ignored.
- ENTRIES, 2, BTB entries (power of 2); IDX_W = log2(ENTRIES); index = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2].
- FLUSH_CYCLES, 2, cycles flush stays high per mispredict (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetchPC  in  PC_W  current fetch PC.
- predTaken  out  1  drives mux select; 1 = take predTarget.
- predTarget  out  PC_W  drives mux branch-target input.
- resValid  in  1  a branch resolved in EX this cycle.
- resPC  in  PC_W  PC of resolving branch.
- resTaken  in  1  actual outcome.
- resTarget  in  PC_W  actual target.
- resPredTaken  in  1  prediction carried down the pipe for this branch.
- resPredTarget  in  PC_W  predicted target carried down the pipe.
- redirectValid  out  1  one-cycle pulse: load redirectPC into PC.
- redirectPC  out  PC_W  correct next PC.
- flush  out  1  squash younger stages.
- statBranches  out  8  resolved-branch count (see Optional Feature).
- statMispredicts  out  8  mispredict count (see Optional Feature).

Behaviour:
- Entry fields: valid, tag, target[PC_W], ctr[2].
- Reset (async, any state incl. mid-flush): all valid=0, ctr=01, FSM IDLE, redirectValid=0, redirectPC=0, flush=0, flush counter=0, stats=0.
- Lookup (combinational): hit = valid & tag match at index(fetchPC).
  - predTaken = hit & ctr[1].
  - predTarget = hit ? target : fetchPC+4 (mod 2^PC_W).
- Accepted resolution = resValid & FSM IDLE. resValid while in FLUSH is a squashed wrong-path op: no table update, no mispredict, no stats.
- Update on accepted resolution, at clock edge:
  - Hit, taken: ctr saturating +1 (max 11); target=resTarget.
  - Hit, not taken: ctr saturating -1 (min 00); target kept.
  - Miss, taken: allocate/overwrite the indexed entry: valid=1, tag, target=resTarget, ctr=10.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update contents.
- Mispredict detection:
  - actualNext = resTaken ? resTarget : resPC+4.
  - predNext = resPredTaken ? resPredTarget : resPC+4.
  - mispredict = accepted & (actualNext != predNext). All additions wrap mod 2^PC_W.
- FSM IDLE -> FLUSH on mispredict. Next cycle (latency 1):
  - redirectValid=1 for exactly one cycle; redirectPC=actualNext (held until next mispredict).
  - flush=1 for FLUSH_CYCLES consecutive cycles, then FSM returns to IDLE, flush=0.
- No back-to-back redirects while in FLUSH.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: statBranches increments on each accepted resolution; statMispredicts increments on each mispredict. Both 8-bit, saturate at 255, cleared only by reset.
- Undefined: no counter logic; statBranches and statMispredicts tied to 0. Ports always present.

Test Plan:
- Reset, fetchPC=0 -> predTaken=0, predTarget=4, flush=0, redirectValid=0, all stats 0.
- resValid, resPC=4, resTaken=1, resTarget=12, resPredTaken=0 -> next cycle redirectValid=1, redirectPC=12; flush=1 for 2 cycles; afterwards fetchPC=4 gives predTaken=1, predTarget=12.
- Counter saturation, continuing from previous scenario:
  - Three correctly-predicted taken resolutions at PC=4 -> ctr=11.
  - One not-taken -> predTaken still 1.
  - Second not-taken -> predTaken=0, predTarget=12 retained.
- Alias at PC=12 (same index, different tag):
  - Before training, fetchPC=12 -> predTaken=0, predTarget=0 (wrap).
  - Taken resolution at PC=12, target 8 -> fetchPC=12 gives predTaken=1, predTarget=8; fetchPC=4 now misses.
- Wrap-around mispredict: resPC=12, resTaken=0, resPredTaken=1, resPredTarget=4 -> redirectPC=0.
- Flush-window squash: during flush, resValid with a differing outcome -> no table change, no second redirect, stats unchanged.
- Reset mid-flush: assert reset while flush=1 -> flush and redirectValid drop immediately.
